// File: rtl/hex_scan_display_if.sv
// Bus between the 4-bit register bank and the scanned 7-segment driver.
// master drives the register word; slave is the display driver.
interface hex_scan_display_if #(
  parameter int unsigned NUM_DIGITS = 8
);
  localparam int unsigned IW = $clog2(NUM_DIGITS);

  logic                    enable;
  logic [NUM_DIGITS*4-1:0] data_i;
  logic [6:0]              seg_o;
  logic [NUM_DIGITS-1:0]   an_o;
  logic [IW-1:0]           digit_idx_o;
  logic                    frame_o;

  modport master (
    output enable, data_i,
    input  seg_o, an_o, digit_idx_o, frame_o
  );

  modport slave (
    input  enable, data_i,
    output seg_o, an_o, digit_idx_o, frame_o
  );
endinterface

// File: rtl/hex_scan_display.sv
// Time-multiplexed common-anode hex display driver with frame-aligned snapshot
// and optional leading-zero blanking.
module hex_scan_display #(
  parameter int unsigned NUM_DIGITS = 8,
  parameter int unsigned SCAN_DIV   = 50000,
  parameter bit          BLANK_LZ   = 1'b1
) (
  input  logic               clk50M,
  input  logic               rst,
  hex_scan_display_if.slave  bus
);
  localparam int unsigned PW = $clog2(SCAN_DIV);
  localparam int unsigned IW = $clog2(NUM_DIGITS);
  localparam int unsigned DW = NUM_DIGITS * 4;

  logic [PW-1:0]         presc_q, presc_d;
  logic [IW-1:0]         index_q, index_d;
  logic [DW-1:0]         snap_q, snap_d;
  logic                  tick_q, tick_d;
  logic [6:0]            seg_q, seg_d;
  logic [NUM_DIGITS-1:0] an_q, an_d;
  logic [IW-1:0]         idx_q, idx_d;
  logic                  frame_q, frame_d;

  logic                  tick;
  logic [NUM_DIGITS-1:0] lz;
  logic                  lz_acc;
  logic [3:0]            cur_dig;
  logic                  cur_lz;

  function automatic logic [6:0] decode(input logic [3:0] v);
    case (v)
      4'h0: decode = 7'h40;
      4'h1: decode = 7'h79;
      4'h2: decode = 7'h24;
      4'h3: decode = 7'h30;
      4'h4: decode = 7'h19;
      4'h5: decode = 7'h12;
      4'h6: decode = 7'h02;
      4'h7: decode = 7'h78;
      4'h8: decode = 7'h00;
      4'h9: decode = 7'h10;
      4'hA: decode = 7'h08;
      4'hB: decode = 7'h03;
      4'hC: decode = 7'h46;
      4'hD: decode = 7'h21;
      4'hE: decode = 7'h06;
      default: decode = 7'h0E;
    endcase
  endfunction

  always_ff @(posedge clk50M or posedge rst) begin
    if (rst) begin
      presc_q <= '0;
      index_q <= IW'(NUM_DIGITS - 1);
      snap_q  <= '0;
      tick_q  <= 1'b0;
      seg_q   <= 7'h7F;
      an_q    <= '1;
      idx_q   <= '0;
      frame_q <= 1'b0;
    end else begin
      presc_q <= presc_d;
      index_q <= index_d;
      snap_q  <= snap_d;
      tick_q  <= tick_d;
      seg_q   <= seg_d;
      an_q    <= an_d;
      idx_q   <= idx_d;
      frame_q <= frame_d;
    end
  end

  // Scan pacing and frame-boundary snapshot.
  always_comb begin
    tick    = (presc_q == PW'(SCAN_DIV - 1));
    presc_d = tick ? '0 : presc_q + 1'b1;
    index_d = index_q;
    snap_d  = snap_q;
    tick_d  = tick;
    if (tick) begin
      if (index_q == IW'(NUM_DIGITS - 1)) begin
        index_d = '0;
        if (!bus.enable) begin
          snap_d = bus.data_i;
        end
      end else begin
        index_d = index_q + 1'b1;
      end
    end
  end

  // lz[k] is set when snapshot digits k..NUM_DIGITS-1 are all zero.
  always_comb begin
    lz     = '0;
    lz_acc = 1'b1;
    for (int unsigned k = 0; k < NUM_DIGITS; k++) begin
      lz_acc = lz_acc & (snap_q[(NUM_DIGITS-1-k)*4 +: 4] == 4'h0);
      lz[NUM_DIGITS-1-k] = lz_acc;
    end
  end

  always_comb begin
    cur_dig = 4'h0;
    cur_lz  = 1'b0;
    for (int unsigned k = 0; k < NUM_DIGITS; k++) begin
      if (index_q == IW'(k)) begin
        cur_dig = snap_q[k*4 +: 4];
        cur_lz  = lz[k];
      end
    end
  end

  // Output stage refreshes the cycle after a tick, from the already-advanced index.
  always_comb begin
    seg_d   = seg_q;
    an_d    = an_q;
    idx_d   = idx_q;
    frame_d = 1'b0;
    if (tick_q) begin
      seg_d = (BLANK_LZ && (index_q != '0) && cur_lz) ? 7'h7F : decode(cur_dig);
      for (int unsigned k = 0; k < NUM_DIGITS; k++) begin
        an_d[k] = (index_q != IW'(k));
      end
      idx_d   = index_q;
      frame_d = (index_q == '0);
    end
  end

  assign bus.seg_o       = seg_q;
  assign bus.an_o        = an_q;
  assign bus.digit_idx_o = idx_q;
  assign bus.frame_o     = frame_q;
endmodule

// File: tb/tb_hex_scan_display.sv
// Self-checking bench for hex_scan_display: two instances (blanking on/off)
// compared every cycle against a frame/slot arithmetic reference model.
module tb_hex_scan_display;
  localparam int S = 4;
  localparam int N = 8;

  typedef struct packed {
    logic [6:0] seg;
    logic [7:0] an;
    logic [2:0] idx;
    logic       frame;
  } out_t;

  localparam out_t RST_VAL = '{seg: 7'h7F, an: 8'hFF, idx: 3'd0, frame: 1'b0};

  logic clk50M = 1'b0;
  logic rst    = 1'b1;
  always #5 clk50M = ~clk50M;

  hex_scan_display_if #(.NUM_DIGITS(N)) bus ();
  hex_scan_display_if #(.NUM_DIGITS(N)) nb_bus ();

  assign nb_bus.enable = bus.enable;
  assign nb_bus.data_i = bus.data_i;

  hex_scan_display #(.NUM_DIGITS(N), .SCAN_DIV(S), .BLANK_LZ(1'b1)) dut (
    .clk50M(clk50M), .rst(rst), .bus(bus)
  );

  hex_scan_display #(.NUM_DIGITS(N), .SCAN_DIV(S), .BLANK_LZ(1'b0)) dut_nb (
    .clk50M(clk50M), .rst(rst), .bus(nb_bus)
  );

  int vecs = 0;
  int errs = 0;

  logic [6:0] seg_tab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                               7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  // Reference state: n = rising edges since reset release; msnap = word latched
  // at the last frame boundary; dsnap = word in use for the slot being shown.
  int          n = 0;
  logic [31:0] msnap = '0;
  logic [31:0] dsnap = '0;

  always @(posedge clk50M or posedge rst) begin
    if (rst) begin
      n     <= 0;
      msnap <= '0;
      dsnap <= '0;
    end else begin
      n <= n + 1;
      if (((n + 1) % S == 0) && ((((n + 1) / S) - 1) % N == 0) && !bus.enable)
        msnap <= bus.data_i;
      if ((n + 1 > S) && (n % S == 0))
        dsnap <= msnap;
    end
  end

  function automatic out_t model_out(input int n_, input logic [31:0] ds, input bit blank);
    out_t        o;
    int          m, d;
    logic [3:0]  dig;
    logic [31:0] upper;
    o = RST_VAL;
    if (n_ <= S) return o;
    m       = (n_ - 1) / S;
    d       = (m - 1) % N;
    dig     = ds[4*d +: 4];
    upper   = ds >> (4 * d);
    o.an    = ~(8'b1 << d);
    o.idx   = 3'(d);
    o.frame = ((n_ - 1) % S == 0) && (d == 0);
    o.seg   = (blank && d != 0 && upper == 0) ? 7'h7F : seg_tab[dig];
    return o;
  endfunction

  function automatic out_t act_main();
    return {bus.seg_o, bus.an_o, bus.digit_idx_o, bus.frame_o};
  endfunction

  function automatic out_t act_nb();
    return {nb_bus.seg_o, nb_bus.an_o, nb_bus.digit_idx_o, nb_bus.frame_o};
  endfunction

  task automatic test_reset();
    out_t a;
    rst = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk50M);
      bus.data_i = $urandom;
      bus.enable = 1'($urandom);
      a = act_main(); vecs++;
      if (a !== RST_VAL) begin errs++; $display("FAIL reset_main got %h exp %h", a, RST_VAL); end
      a = act_nb(); vecs++;
      if (a !== RST_VAL) begin errs++; $display("FAIL reset_nb got %h exp %h", a, RST_VAL); end
    end
  endtask

  task automatic test_basic_scan();
    out_t a, e;
    bus.data_i = 32'h0000_00A5;
    bus.enable = 1'b0;
    @(negedge clk50M);
    rst = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk50M);
      a = act_main(); e = model_out(n, dsnap, 1'b1); vecs++;
      if (a !== e) begin errs++; $display("FAIL basic_main n=%0d got %h exp %h", n, a, e); end
      a = act_nb(); e = model_out(n, dsnap, 1'b0); vecs++;
      if (a !== e) begin errs++; $display("FAIL basic_nb n=%0d got %h exp %h", n, a, e); end
      if (n == 5) begin
        vecs++;
        if (bus.an_o !== 8'hFE || bus.seg_o !== 7'h12 || bus.frame_o !== 1'b1) begin
          errs++; $display("FAIL basic_edge5 got an=%h seg=%h fr=%b exp an=fe seg=12 fr=1",
                           bus.an_o, bus.seg_o, bus.frame_o);
        end
      end
      if (n == 9) begin
        vecs++;
        if (bus.an_o !== 8'hFD || bus.seg_o !== 7'h08) begin
          errs++; $display("FAIL basic_edge9 got an=%h seg=%h exp an=fd seg=08", bus.an_o, bus.seg_o);
        end
      end
      if (n >= 13 && n <= 36) begin
        vecs++;
        if (bus.seg_o !== 7'h7F) begin
          errs++; $display("FAIL basic_blank n=%0d got seg=%h exp 7f", n, bus.seg_o);
        end
      end
      if (n == 37) begin
        vecs++;
        if (bus.frame_o !== 1'b1) begin
          errs++; $display("FAIL basic_edge37 got frame=%b exp 1", bus.frame_o);
        end
      end
    end
  endtask

  task automatic test_hold();
    out_t a, e;
    bus.enable = 1'b1;
    bus.data_i = 32'hFFFF_FFFF;
    for (int i = 0; i < 2 * N * S; i++) begin
      @(negedge clk50M);
      a = act_main(); e = model_out(n, dsnap, 1'b1); vecs++;
      if (a !== e) begin errs++; $display("FAIL hold_main n=%0d got %h exp %h", n, a, e); end
      vecs++;
      if (n > S + 1 && bus.an_o == 8'hFE && bus.seg_o !== 7'h12) begin
        errs++; $display("FAIL hold_digit0 n=%0d got seg=%h exp 12", n, bus.seg_o);
      end
    end
    bus.enable = 1'b0;
    bus.data_i = 32'h1234_5678;
    for (int i = 0; i < 2 * N * S; i++) begin
      @(negedge clk50M);
      a = act_main(); e = model_out(n, dsnap, 1'b1); vecs++;
      if (a !== e) begin errs++; $display("FAIL reload_main n=%0d got %h exp %h", n, a, e); end
      a = act_nb(); e = model_out(n, dsnap, 1'b0); vecs++;
      if (a !== e) begin errs++; $display("FAIL reload_nb n=%0d got %h exp %h", n, a, e); end
    end
  endtask

  task automatic test_blanking(input logic [31:0] word, input logic [6:0] exp_main [8],
                               input logic [6:0] exp_nb [8]);
    bit seen;
    bus.enable = 1'b0;
    bus.data_i = word;
    // skip past the next boundary, then align to a frame start
    repeat (N * S + 2) @(negedge clk50M);
    seen = 1'b0;
    for (int i = 0; i < N * S + 2 && !seen; i++) begin
      @(negedge clk50M);
      if (bus.frame_o === 1'b1) seen = 1'b1;
    end
    vecs++;
    if (!seen) begin errs++; $display("FAIL blank_align got no frame_o exp pulse"); end
    for (int i = 0; i < N * S; i++) begin
      if (i != 0) @(negedge clk50M);
      vecs++;
      if (bus.seg_o !== exp_main[i / S]) begin
        errs++; $display("FAIL blank_main word=%h digit=%0d got %h exp %h",
                         word, i / S, bus.seg_o, exp_main[i / S]);
      end
      vecs++;
      if (nb_bus.seg_o !== exp_nb[i / S]) begin
        errs++; $display("FAIL blank_nb word=%h digit=%0d got %h exp %h",
                         word, i / S, nb_bus.seg_o, exp_nb[i / S]);
      end
    end
  endtask

  task automatic test_decode_sweep(input logic [31:0] word);
    out_t a, e;
    bus.enable = 1'b0;
    bus.data_i = word;
    for (int i = 0; i < 2 * N * S; i++) begin
      @(negedge clk50M);
      a = act_main(); e = model_out(n, dsnap, 1'b1); vecs++;
      if (a !== e) begin errs++; $display("FAIL sweep_main n=%0d got %h exp %h", n, a, e); end
      a = act_nb(); e = model_out(n, dsnap, 1'b0); vecs++;
      if (a !== e) begin errs++; $display("FAIL sweep_nb n=%0d got %h exp %h", n, a, e); end
      vecs++;
      if ($countones(~bus.an_o) != 1) begin
        errs++; $display("FAIL sweep_onehot n=%0d got an=%h exp one-hot-low", n, bus.an_o);
      end
    end
  endtask

  task automatic test_random();
    out_t a, e;
    logic [31:0] w;
    int k;
    for (int i = 0; i < 10 * N * S; i++) begin
      @(negedge clk50M);
      a = act_main(); e = model_out(n, dsnap, 1'b1); vecs++;
      if (a !== e) begin errs++; $display("FAIL rand_main n=%0d got %h exp %h", n, a, e); end
      a = act_nb(); e = model_out(n, dsnap, 1'b0); vecs++;
      if (a !== e) begin errs++; $display("FAIL rand_nb n=%0d got %h exp %h", n, a, e); end
      if ($urandom_range(0, 7) == 0) begin
        w = $urandom;
        k = $urandom_range(0, 8);
        if (k < 8) w = w & (32'hFFFF_FFFF >> (4 * (8 - k)));
        bus.data_i = w;
      end
      if ($urandom_range(0, 3) == 0) bus.enable = 1'($urandom);
    end
  endtask

  task automatic test_reset_midframe();
    out_t a, e;
    repeat (13) @(negedge clk50M);
    #2 rst = 1'b1;
    #1;
    a = act_main(); vecs++;
    if (a !== RST_VAL) begin errs++; $display("FAIL midrst_main got %h exp %h", a, RST_VAL); end
    a = act_nb(); vecs++;
    if (a !== RST_VAL) begin errs++; $display("FAIL midrst_nb got %h exp %h", a, RST_VAL); end
    @(negedge clk50M);
    bus.enable = 1'b0;
    bus.data_i = $urandom;
    rst = 1'b0;
    for (int i = 0; i < N * S + 8; i++) begin
      @(negedge clk50M);
      a = act_main(); e = model_out(n, dsnap, 1'b1); vecs++;
      if (a !== e) begin errs++; $display("FAIL restart_main n=%0d got %h exp %h", n, a, e); end
      a = act_nb(); e = model_out(n, dsnap, 1'b0); vecs++;
      if (a !== e) begin errs++; $display("FAIL restart_nb n=%0d got %h exp %h", n, a, e); end
    end
  endtask

  initial begin
    logic [6:0] z_main [8];
    logic [6:0] z_nb   [8];
    bus.enable = 1'b1;
    bus.data_i = '0;
    test_reset();
    test_basic_scan();
    test_hold();
    z_main = '{7'h40, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F};
    z_nb   = '{7'h40, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40};
    test_blanking(32'h0000_0000, z_main, z_nb);
    z_main = '{7'h40, 7'h30, 7'h40, 7'h24, 7'h40, 7'h79, 7'h7F, 7'h7F};
    z_nb   = '{7'h40, 7'h30, 7'h40, 7'h24, 7'h40, 7'h79, 7'h40, 7'h40};
    test_blanking(32'h0010_2030, z_main, z_nb);
    test_decode_sweep(32'hFEDC_BA98);
    test_decode_sweep(32'h7654_3210);
    test_random();
    test_reset_midframe();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
